// File: rtl/md_unit.sv
// Iterative MIPS multiply/divide unit holding HI/LO, with hazard stall request.
// Optional macro MD_FAST_MUL_EN: single-cycle multiply in RUN (divide stays iterative).
module md_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             MdStartE,
    input  logic [1:0]       MdOpE,
    input  logic             MtHiE,
    input  logic             MtLoE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             HiLoUseD,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             MdBusy,
    output logic             MdStallD,
    output logic             MdDone
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 div_q;
    logic                 neg_q;
    logic                 rem_neg_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 op_signed;
    logic                 op_div;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [2*WIDTH-1:0]   acc_d;
    logic                 run_last;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic [WIDTH-1:0]     hi_d;
    logic [WIDTH-1:0]     lo_d;
`ifndef MD_FAST_MUL_EN
    logic [WIDTH:0]       mul_sum;
`endif

    assign op_signed = ~MdOpE[0];
    assign op_div    = MdOpE[1];
    assign a_mag     = (op_signed && SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
    assign b_mag     = (op_signed && SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;

    // acc_q holds {partial product high, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, b_q};
`ifdef MD_FAST_MUL_EN
        run_last  = !div_q || (cnt_q == CNT_W'(WIDTH-1));
`else
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? a_q : {WIDTH{1'b0}})};
        run_last  = (cnt_q == CNT_W'(WIDTH-1));
`endif
        if (div_q) begin
            if (div_diff[WIDTH])
                acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            else
                acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
`ifdef MD_FAST_MUL_EN
            acc_d = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
`else
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
`endif
        end
    end

    // Sign restoration applied on the FIX cycle.
    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        hi_d     = div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        lo_d     = div_q ? quo_fix : prod_fix[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            div_q     <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (MdStartE) begin
                        state_q   <= S_RUN;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        div_q     <= op_div;
                        // Divide by zero keeps the all-ones quotient unsigned-looking.
                        neg_q     <= op_signed && (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1])
                                     && !(op_div && (SrcBE == '0));
                        rem_neg_q <= op_signed && SrcAE[WIDTH-1];
                        a_q       <= a_mag;
                        b_q       <= b_mag;
                        acc_q     <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
                    end else begin
                        if (MtHiE) hi_q <= SrcAE;
                        if (MtLoE) lo_q <= SrcAE;
                    end
                end
                S_RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (run_last) state_q <= S_FIX;
                end
                S_FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Hi       = hi_q;
    assign Lo       = lo_q;
    assign MdBusy   = busy_q;
    assign MdDone   = done_q;
    assign MdStallD = busy_q && HiLoUseD;

endmodule
